readout_tx_measurement_sequencer: RTL and testbench

Transmit-side sequencer for one qubit readout channel. It accepts a measurement request and gates the readout drive tone for a programmed number of cycles. It then frames the RX integration window by pulsing `start_count_out` and `finish_count_out`, which feed the RX integrator and state-decision logic. Finally it captures the single-cycle `valid_meas_result`/`meas_result` pair returned by the RX decision stage, or times out, and reports one completion pulse upstream.

---
 rtl/readout_tx_measurement_sequencer.sv | 142 ++++++++++++++
 tb/tb_readout_tx_measurement_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/readout_tx_measurement_sequencer.sv
// Transmit-side measurement sequencer for one qubit readout channel: gates the drive tone,
// frames the RX integration window, then captures the RX decision or times out.
module readout_tx_measurement_sequencer #(
    parameter int DRIVE_W      = 10,
    parameter int INTEG_W      = 10,
    parameter int WAIT_TIMEOUT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               meas_req_in,
    input  logic [DRIVE_W-1:0] drive_cycles_in,
    input  logic [INTEG_W-1:0] integ_cycles_in,
    output logic               meas_ready_out,
    output logic               drive_en_out,
    output logic               integ_en_out,
    output logic               start_count_out,
    output logic               finish_count_out,
    input  logic               valid_meas_result_in,
    input  logic               meas_result_in,
    output logic               meas_done_out,
    output logic               meas_result_out,
    output logic               timeout_out
);

    localparam int WAIT_W = $clog2(WAIT_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_INTEG,
        ST_WAIT
    } state_t;

    state_t             state;
    logic [DRIVE_W-1:0] drive_cnt;
    logic [INTEG_W-1:0] integ_cnt;
    logic [INTEG_W-1:0] integ_len;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               start_q;
    logic               finish_q;
    logic               done_q;
    logic               result_q;
    logic               timeout_q;

    // A zero integration length still runs one INTEG cycle.
    function automatic logic [INTEG_W-1:0] integ_first(input logic [INTEG_W-1:0] len);
        return (len == '0) ? '0 : len - INTEG_W'(1);
    endfunction

    function automatic logic integ_single(input logic [INTEG_W-1:0] len);
        return len <= INTEG_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            drive_cnt <= '0;
            integ_cnt <= '0;
            integ_len <= '0;
            wait_cnt  <= '0;
            start_q   <= 1'b0;
            finish_q  <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            // NOTE: pulse registers default low every cycle so each one is exactly one cycle wide;
            // only the transition that owns a pulse raises it.
            start_q   <= 1'b0;
            finish_q  <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= 1'b0;
            timeout_q <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (meas_req_in) begin
                        integ_len <= integ_cycles_in;
                        if (drive_cycles_in != '0) begin
                            state     <= ST_DRIVE;
                            drive_cnt <= drive_cycles_in - DRIVE_W'(1);
                        end else begin
                            state     <= ST_INTEG;
                            integ_cnt <= integ_first(integ_cycles_in);
                            start_q   <= 1'b1;
                            finish_q  <= integ_single(integ_cycles_in);
                        end
                    end
                end

                ST_DRIVE: begin
                    if (drive_cnt == '0) begin
                        state     <= ST_INTEG;
                        integ_cnt <= integ_first(integ_len);
                        start_q   <= 1'b1;
                        finish_q  <= integ_single(integ_len);
                    end else begin
                        drive_cnt <= drive_cnt - DRIVE_W'(1);
                    end
                end

                ST_INTEG: begin
                    if (integ_cnt == '0) begin
                        state    <= ST_WAIT;
                        wait_cnt <= '0;
                    end else begin
                        integ_cnt <= integ_cnt - INTEG_W'(1);
                        finish_q  <= (integ_cnt == INTEG_W'(1));
                    end
                end

                ST_WAIT: begin
                    // A result arriving in the final WAIT cycle takes priority over the timeout.
                    if (valid_meas_result_in) begin
                        state    <= ST_IDLE;
                        done_q   <= 1'b1;
                        result_q <= meas_result_in;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state     <= ST_IDLE;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign meas_ready_out   = (state == ST_IDLE);
    assign drive_en_out     = (state == ST_DRIVE);
    assign integ_en_out     = (state == ST_INTEG);
    assign start_count_out  = start_q;
    assign finish_count_out = finish_q;
    assign meas_done_out    = done_q;
    assign meas_result_out  = result_q;
    assign timeout_out      = timeout_q;

endmodule

// File: tb/tb_readout_tx_measurement_sequencer.sv
// Scoreboard bench for readout_tx_measurement_sequencer: directed measurements push expected
// start/finish/done events; a negedge monitor pops and compares them as the DUT emits them.
module tb_readout_tx_measurement_sequencer;

    localparam int DRIVE_W  = 10;
    localparam int INTEG_W  = 10;
    localparam int WT       = 4;
    localparam int CLK_HALF = 5;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               meas_req = 1'b0;
    logic [DRIVE_W-1:0] drive_cycles = '0;
    logic [INTEG_W-1:0] integ_cycles = '0;
    logic               valid = 1'b0;
    logic               result = 1'b0;
    logic               meas_ready_out;
    logic               drive_en_out;
    logic               integ_en_out;
    logic               start_count_out;
    logic               finish_count_out;
    logic               meas_done_out;
    logic               meas_result_out;
    logic               timeout_out;

    readout_tx_measurement_sequencer #(
        .DRIVE_W      (DRIVE_W),
        .INTEG_W      (INTEG_W),
        .WAIT_TIMEOUT (WT)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .meas_req_in          (meas_req),
        .drive_cycles_in      (drive_cycles),
        .integ_cycles_in      (integ_cycles),
        .meas_ready_out       (meas_ready_out),
        .drive_en_out         (drive_en_out),
        .integ_en_out         (integ_en_out),
        .start_count_out      (start_count_out),
        .finish_count_out     (finish_count_out),
        .valid_meas_result_in (valid),
        .meas_result_in       (result),
        .meas_done_out        (meas_done_out),
        .meas_result_out      (meas_result_out),
        .timeout_out          (timeout_out)
    );

    always #CLK_HALF clk = ~clk;

    // Cycle label as seen at a negedge: the request accepted at the next posedge is in cycle cyc.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   at;
        logic res;
        logic to;
        int   dcnt;
        int   icnt;
    } done_t;

    int    exp_start[$];
    int    exp_finish[$];
    done_t exp_done[$];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a pulse.
    int    drive_seen = 0;
    int    integ_seen = 0;
    int    e_cyc;
    done_t e_done;

    always @(negedge clk) begin
        if (rst) begin
            drive_seen = 0;
            integ_seen = 0;
        end else begin
            if (drive_en_out) drive_seen++;
            if (integ_en_out) integ_seen++;
            if (start_count_out) begin
                if (exp_start.size() == 0) check("start_unexpected", 1, 0);
                else begin
                    e_cyc = exp_start.pop_front();
                    check("start_cycle", cyc, e_cyc);
                end
            end
            if (finish_count_out) begin
                if (exp_finish.size() == 0) check("finish_unexpected", 1, 0);
                else begin
                    e_cyc = exp_finish.pop_front();
                    check("finish_cycle", cyc, e_cyc);
                end
            end
            if (meas_done_out) begin
                if (exp_done.size() == 0) check("done_unexpected", 1, 0);
                else begin
                    e_done = exp_done.pop_front();
                    check("done_cycle", cyc, e_done.at);
                    check("done_result", meas_result_out, e_done.res);
                    check("done_timeout", timeout_out, e_done.to);
                    check("done_ready", meas_ready_out, 1);
                    check("drive_len", drive_seen, e_done.dcnt);
                    check("integ_len", integ_seen, e_done.icnt);
                end
                drive_seen = 0;
                integ_seen = 0;
            end else begin
                check("result_zero_when_idle", {meas_result_out, timeout_out}, 0);
            end
        end
    end

    // vmode: 0 = RX silent, 1 = reply in first WAIT cycle, 2 = reply in last WAIT cycle.
    // Timeout completion lands at D+I+1+WT; a reply at cycle v completes at v+1.
    task automatic do_meas(input int d, input int i, input int vmode, input logic res,
                           input bit hold, input bit stray);
        int    budget;
        int    c0;
        int    ie;
        int    vk;
        int    done_k;
        done_t e;
        budget = 0;
        while (!meas_ready_out && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (!meas_ready_out) begin
            check("ready_wait", 0, 1);
            return;
        end
        ie = (i == 0) ? 1 : i;
        c0 = cyc;
        meas_req     = 1'b1;
        drive_cycles = DRIVE_W'(d);
        integ_cycles = INTEG_W'(i);
        valid        = 1'b0;
        case (vmode)
            1:       begin vk = d + ie + 1;  done_k = d + ie + 2;      end
            2:       begin vk = d + ie + WT; done_k = d + ie + WT + 1; end
            default: begin vk = -1;          done_k = d + ie + 1 + WT; end
        endcase
        exp_start.push_back(c0 + d + 1);
        exp_finish.push_back(c0 + d + ie);
        e.at   = c0 + done_k;
        e.res  = (vmode != 0) ? res : 1'b0;
        e.to   = (vmode == 0);
        e.dcnt = d;
        e.icnt = ie;
        exp_done.push_back(e);
        for (int k = 1; k <= done_k; k++) begin
            @(negedge clk);
            meas_req = hold;
            valid    = (k == vk) || (stray && k <= d + ie && k[0]);
            result   = (k == vk) ? res : ~res;
        end
        valid = 1'b0;
    endtask

    // Reset in the middle of INTEG (D=4, I=10, cycle 7), then idle with no events expected.
    task automatic do_reset_mid();
        int c0;
        c0 = cyc;
        meas_req     = 1'b1;
        drive_cycles = DRIVE_W'(4);
        integ_cycles = INTEG_W'(10);
        exp_start.push_back(c0 + 5);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            meas_req = 1'b0;
        end
        check("integ_before_rst", integ_en_out, 1);
        #1 rst = 1'b1;
        #1;
        check("rst_ready", meas_ready_out, 1);
        check("rst_drive_en", drive_en_out, 0);
        check("rst_integ_en", integ_en_out, 0);
        check("rst_start", start_count_out, 0);
        check("rst_finish", finish_count_out, 0);
        check("rst_done", meas_done_out, 0);
        check("rst_result", meas_result_out, 0);
        check("rst_timeout", timeout_out, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        check("reset_ready", meas_ready_out, 1);
        check("reset_drive_en", drive_en_out, 0);
        check("reset_integ_en", integ_en_out, 0);
        check("reset_start", start_count_out, 0);
        check("reset_finish", finish_count_out, 0);
        check("reset_done", meas_done_out, 0);
        check("reset_result", meas_result_out, 0);
        check("reset_timeout", timeout_out, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_meas(3, 5, 1, 1'b1, 1'b0, 1'b0);   // start 4, finish 8, done 10 result 1
        do_meas(0, 1, 1, 1'b0, 1'b0, 1'b0);   // start/finish 1, done 3 result 0
        do_meas(2, 2, 0, 1'b0, 1'b0, 1'b0);   // silent RX: timeout at 9
        do_meas(2, 2, 2, 1'b1, 1'b0, 1'b0);   // reply in last WAIT cycle 8: done 9, no timeout
        do_meas(1, 0, 1, 1'b1, 1'b0, 1'b0);   // I=0 behaves as I=1
        do_meas(3, 2, 1, 1'b1, 1'b1, 1'b1);   // request held, stray valids in DRIVE/INTEG
        do_meas(1, 3, 1, 1'b0, 1'b0, 1'b0);   // accepted in the done cycle of the previous one
        do_reset_mid();
        do_meas(2, 3, 1, 1'b1, 1'b0, 1'b0);
        do_meas(1023, 1023, 1, 1'b1, 1'b0, 1'b0);

        repeat (10) @(negedge clk);
        check("pending_start", exp_start.size(), 0);
        check("pending_finish", exp_finish.size(), 0);
        check("pending_done", exp_done.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
